integral_window_builder: RTL and testbench
==========================================

# integral_window_builder

Producer for the face classifier's window input: accepts a raster-order stream of grey pixels, builds the 20x20 integral image of one detection window in a register array, and presents it as a flattened bus with a valid flag. It sits upstream of the cascade classifier: `window_valid` drives the classifier `en`, `image` drives its `image`, and the classifier's `request_new_data` pulse frees the window for the next fill.

## Interface

Parameters:
- `WIDTH`, default 20: window side in pixels; window holds WIDTH*WIDTH entries.
- `BITSIZE`, default 9: bits per integral-image entry.
- `PIXEL_WIDTH`, default 8: bits per input pixel, unsigned.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: one clock; reset is asynchronous and active-high.
- `pixel_in`, input, PIXEL_WIDTH: pixel value, raster order (row 0 col 0 first).
- `pixel_valid`, input, 1: `pixel_in` carries a pixel this cycle.
- `pixel_ready`, output, 1: block accepts a pixel this cycle.
- `request_new_data`, input, 1: classifier done with the current window.
- `image`, output, WIDTH*WIDTH*BITSIZE: integral window; entry k = y*WIDTH+x at bits [k*BITSIZE +: BITSIZE].
- `window_valid`, output, 1: `image` holds a complete window.

## Operation

- Entry (x,y) = sum of pixels at rows 0..y, cols 0..x (inclusive), computed modulo 2^BITSIZE. Wrap is intentional: any rectangle difference A-B-C+D whose true value fits in BITSIZE bits is exact.
- Pixel zero-extended to BITSIZE before adding; no saturation anywhere.
- Counters: `col` 0..WIDTH-1, `row` 0..WIDTH-1, plus BITSIZE-bit `row_sum`.
- Per accepted pixel p at (col,row): row_sum_next = (col==0 ? 0 : row_sum) + p; entry(col,row) <= row_sum_next + (row==0 ? 0 : entry(col,row-1)). Above-entry read is a mux at index k-WIDTH of the array itself.
- After the write: col wraps WIDTH-1 -> 0 and row increments; at (WIDTH-1,WIDTH-1) both return to 0.
- States:
  - FILL: `pixel_ready`=1, `window_valid`=0. Accept on `pixel_valid`&&`pixel_ready`. Acceptance of pixel WIDTH*WIDTH-1 -> READY.
  - READY: `pixel_ready`=0, `window_valid`=1, `image` frozen. `request_new_data`=1 -> FILL with col=row=0, row_sum=0.
- `request_new_data` in FILL ignored (no counter change).
- Array is not cleared on leaving READY; every entry is overwritten before the next READY.
- `pixel_ready` is a decode of state only (no combinational path from `pixel_valid` or `request_new_data`).
- Pixels offered while `pixel_ready`=0 are not consumed; source must hold them.

## Timing

- Reset (async assert): state FILL, col=row=0, row_sum=0, all entries 0, `image`=0, `window_valid`=0, `pixel_ready`=1 (once state decodes FILL).
- Reset mid-fill or mid-READY: partial window discarded; next accepted pixel is (0,0).
- Throughput: one pixel per cycle; minimum fill = WIDTH*WIDTH cycles (400 default).
- Entry for a pixel accepted at edge N is visible on `image` after edge N.
- Last pixel accepted at edge N: entry 399 written and `window_valid` rises on the same edge N; `pixel_ready` low from then.
- `request_new_data` sampled high at edge M in READY: `window_valid` low and `pixel_ready` high after edge M; first new pixel accepted at edge M+1 at earliest.
- `request_new_data` held high multiple cycles: only the READY->FILL transition acts; extra cycles land in FILL and are ignored.
- `pixel_valid` gaps: counters hold; no entry changes.

## Test plan

- All pixels = 1, continuous valid: `window_valid` rises exactly 400 cycles after first acceptance; entry(0,0)=1, entry(4,2)=15, entry(19,0)=20, entry(19,19)=400 mod 512=400.
- All pixels = 255: entry(0,0)=255, entry(1,1)=1020 mod 512=508; rectangle check entry(1,1)-entry(0,1)-entry(1,0)+entry(0,0) mod 512 = 255.
- Handshake: in READY, hold `pixel_valid`=1 for 10 cycles -> `pixel_ready`=0, `image` unchanged; pulse `request_new_data` -> `window_valid`=0 next cycle, next pixel written to entry 0.
- `request_new_data` pulsed mid-fill after 37 pixels -> no effect; fill completes after 400 total pixels with correct values.
- Random `pixel_valid` gaps (~50% duty), pixel = (x+y) mod 256 -> array matches software integral model mod 512; `window_valid` only after 400th accepted pixel.
- Assert `rst` after 250 pixels, then stream a fresh all-1 window -> `window_valid`=0 and `image`=0 during reset; resulting window identical to the first scenario.

Source files
------------

// File: rtl/integral_window_builder_if.sv
// rtl/integral_window_builder_if.sv - pixel stream, window bus and release handshake of the integral window builder
//
// Signals (direction seen from the builder, i.e. the slave modport):
//   pixel_in          in   PIXEL_WIDTH        raster-order grey pixel
//   pixel_valid       in   1                  pixel_in carries a pixel
//   pixel_ready       out  1                  builder accepts a pixel this cycle
//   request_new_data  in   1                  consumer is done with the current window
//   image             out  WIDTH*WIDTH*BITSIZE integral window, entry k at [k*BITSIZE +: BITSIZE]
//   window_valid      out  1                  image holds a complete window
// The master modport is the pixel source / window consumer side.

interface integral_window_builder_if #(
    parameter int WIDTH       = 20,
    parameter int BITSIZE     = 9,
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0]           pixel_in;
    logic                             pixel_valid;
    logic                             pixel_ready;
    logic                             request_new_data;
    logic [WIDTH*WIDTH*BITSIZE-1:0]   image;
    logic                             window_valid;

    modport master (
        output pixel_in, pixel_valid, request_new_data,
        input  pixel_ready, image, window_valid
    );

    modport slave (
        input  pixel_in, pixel_valid, request_new_data,
        output pixel_ready, image, window_valid
    );
endinterface

// File: rtl/integral_window_builder.sv
// rtl/integral_window_builder.sv - builds the integral image of one detection window from a raster pixel stream
//
// Ports:
//   clk   in  single clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   slave modport of integral_window_builder_if (pixel stream in, integral window out)
// Entry (x,y) holds the sum of all pixels in rows 0..y, cols 0..x, modulo 2^BITSIZE.
// The window is filled in FILL and held frozen in READY until request_new_data.

module integral_window_builder #(
    parameter int WIDTH       = 20,
    parameter int BITSIZE     = 9,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    integral_window_builder_if.slave    bus
);
    localparam int NE = WIDTH * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int KW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        col;
    logic [CW-1:0]        row;
    logic [BITSIZE-1:0]   row_sum;
    logic [BITSIZE-1:0]   entry [NE];

    logic                 accept;
    logic                 last;
    logic [KW-1:0]        idx;
    logic [KW-1:0]        above_idx;
    logic [BITSIZE-1:0]   row_sum_next;
    logic [BITSIZE-1:0]   above;
    logic [BITSIZE-1:0]   entry_next;

    assign accept    = (state == FILL) && bus.pixel_valid;
    assign last      = (col == CW'(WIDTH - 1)) && (row == CW'(WIDTH - 1));
    assign idx       = KW'(row) * KW'(WIDTH) + KW'(col);
    // Underflows on row 0, but the mux below never selects it there.
    assign above_idx = idx - KW'(WIDTH);

    // Running row sum plus the entry directly above gives the integral entry;
    // all arithmetic wraps at BITSIZE bits on purpose.
    assign row_sum_next = ((col == '0) ? '0 : row_sum) + BITSIZE'(bus.pixel_in);
    assign above        = (row == '0) ? '0 : entry[above_idx];
    assign entry_next   = row_sum_next + above;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        bus.pixel_ready  = 1'b0;
        bus.window_valid = 1'b0;
        case (state)
            FILL: begin
                bus.pixel_ready = 1'b1;
                if (accept && last) begin
                    state_next = READY;
                end
            end
            READY: begin
                bus.window_valid = 1'b1;
                if (bus.request_new_data) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            row_sum <= '0;
            for (int k = 0; k < NE; k++) begin
                entry[k] <= '0;
            end
        end else if (accept) begin
            entry[idx] <= entry_next;
            row_sum    <= row_sum_next;
            if (col == CW'(WIDTH - 1)) begin
                col <= '0;
                row <= last ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end else if ((state == READY) && bus.request_new_data) begin
            col     <= '0;
            row     <= '0;
            row_sum <= '0;
        end
    end

    for (genvar k = 0; k < NE; k++) begin : g_image
        assign bus.image[k*BITSIZE +: BITSIZE] = entry[k];
    end
endmodule

// File: tb/tb_integral_window_builder.sv
// tb/tb_integral_window_builder.sv - directed self-checking bench for integral_window_builder

module tb_integral_window_builder;
    localparam int WIDTH       = 20;
    localparam int BITSIZE     = 9;
    localparam int PIXEL_WIDTH = 8;
    localparam int N           = WIDTH * WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    integral_window_builder_if #(
        .WIDTH(WIDTH), .BITSIZE(BITSIZE), .PIXEL_WIDTH(PIXEL_WIDTH)
    ) bus ();

    integral_window_builder #(
        .WIDTH(WIDTH), .BITSIZE(BITSIZE), .PIXEL_WIDTH(PIXEL_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passed = 0;
    int pix [N];
    logic [N*BITSIZE-1:0] saved;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) passed++;
        else $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    function automatic int entry(input int x, input int y);
        return int'(bus.image[(y*WIDTH + x)*BITSIZE +: BITSIZE]);
    endfunction

    // Direct rectangle summation over the recorded pixels.
    function automatic int model(input int x, input int y);
        int s = 0;
        for (int r = 0; r <= y; r++)
            for (int c = 0; c <= x; c++)
                s += pix[r*WIDTH + c];
        return s % 512;
    endfunction

    function automatic int window_errors();
        int e = 0;
        for (int y = 0; y < WIDTH; y++)
            for (int x = 0; x < WIDTH; x++)
                if (entry(x, y) != model(x, y)) e++;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 all ones, 1 all 255, 2 (x+y)%256. gap: random valid duty.
    // req_at: accepted-pixel count at which request_new_data is raised.
    task automatic fill(input string tag, input int kind, input int gap, input int req_at,
                        output int cycles, output int first_entry);
        int accepted = 0;
        int early = 0;
        int p;
        logic take;
        cycles = 0;
        first_entry = -1;
        while (accepted < N && cycles < 4000) begin
            p = (kind == 0) ? 1 : (kind == 1) ? 255 : ((accepted % WIDTH) + (accepted / WIDTH)) % 256;
            bus.pixel_in = PIXEL_WIDTH'(p);
            bus.pixel_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.request_new_data = (accepted == req_at);
            take = bus.pixel_valid && bus.pixel_ready;
            if (take) pix[accepted] = p;
            step();
            cycles++;
            if (take) begin
                if (accepted == 0) first_entry = entry(0, 0);
                accepted++;
            end
            if (accepted < N && bus.window_valid) early++;
        end
        bus.pixel_valid = 1'b0;
        bus.request_new_data = 1'b0;
        check({tag, "_accepted"}, accepted, N);
        check({tag, "_no_early_valid"}, early, 0);
        check({tag, "_window_valid"}, int'(bus.window_valid), 1);
        check({tag, "_ready_low"}, int'(bus.pixel_ready), 0);
        check({tag, "_window"}, window_errors(), 0);
    endtask

    task automatic release_window(input string tag, input int hold);
        bus.request_new_data = 1'b1;
        step();
        check({tag, "_valid_drop"}, int'(bus.window_valid), 0);
        check({tag, "_ready_rise"}, int'(bus.pixel_ready), 1);
        for (int i = 1; i < hold; i++) step();
        bus.request_new_data = 1'b0;
    endtask

    int cyc;
    int fe;

    initial begin
        rst = 1'b1;
        bus.pixel_in = '0;
        bus.pixel_valid = 1'b0;
        bus.request_new_data = 1'b0;
        #1;
        check("rst_window_valid", int'(bus.window_valid), 0);
        check("rst_image_zero", int'(bus.image != '0), 0);
        check("rst_pixel_ready", int'(bus.pixel_ready), 1);
        step();
        step();
        rst = 1'b0;
        step();

        // all ones, continuous
        fill("ones", 0, 0, -1, cyc, fe);
        check("ones_latency", cyc, 400);
        check("ones_e00", entry(0, 0), 1);
        check("ones_e42", entry(4, 2), 15);
        check("ones_e190", entry(19, 0), 20);
        check("ones_e1919", entry(19, 19), 400);

        // READY holds off the source and freezes the image
        saved = bus.image;
        bus.pixel_in = 8'd7;
        bus.pixel_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 9) check("hold_ready_low", int'(bus.pixel_ready), 0);
        end
        check("hold_image_frozen", int'(bus.image == saved), 1);
        check("hold_window_valid", int'(bus.window_valid), 1);
        bus.pixel_valid = 1'b0;
        release_window("rel1", 1);

        // all 255, request_new_data raised mid-fill after 37 pixels
        fill("sat", 1, 0, 37, cyc, fe);
        check("sat_first_entry", fe, 255);
        check("sat_latency", cyc, 400);
        check("sat_e00", entry(0, 0), 255);
        check("sat_e11", entry(1, 1), 508);
        check("sat_rect", (entry(1, 1) - entry(0, 1) - entry(1, 0) + entry(0, 0)) & 511, 255);

        // request held several cycles; extras land in FILL
        release_window("rel2", 4);
        check("rel2_still_fill", int'(bus.pixel_ready), 1);

        // gappy valid, pixel = (x+y)%256
        fill("gap", 2, 1, -1, cyc, fe);
        check("gap_first_entry", fe, 0);
        check("gap_e1919", entry(19, 19), 7600 % 512);
        release_window("rel3", 1);

        // reset after 250 pixels
        bus.pixel_in = 8'd1;
        bus.pixel_valid = 1'b1;
        for (int i = 0; i < 250; i++) step();
        bus.pixel_valid = 1'b0;
        check("mid_not_valid", int'(bus.window_valid), 0);
        rst = 1'b1;
        #1;
        check("mid_rst_image_zero", int'(bus.image != '0), 0);
        check("mid_rst_window_valid", int'(bus.window_valid), 0);
        step();
        check("mid_rst_image_zero_edge", int'(bus.image != '0), 0);
        rst = 1'b0;
        step();
        fill("ones2", 0, 0, -1, cyc, fe);
        check("ones2_latency", cyc, 400);
        check("ones2_first_entry", fe, 1);
        check("ones2_e42", entry(4, 2), 15);
        check("ones2_e1919", entry(19, 19), 400);
        check("ones2_same_as_first", int'(bus.image == saved), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
